multicycle_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the single-issue datapath around the instruction decode controller. Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB, handshaking with instruction and data memory. Drives the enable strobes for the IR, decode register, ALU result register, register file, data memory and PC, and selects the next-PC source. Detects illegal opcodes and memory timeouts, halting on either.

---
 rtl/multicycle_sequencer_pkg.sv | 39 +++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_sequencer.sv | 173 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcodes, next-PC selects.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ALUR   = 4'h0;
    localparam logic [3:0] OP_CMPR   = 4'h2;
    localparam logic [3:0] OP_SW     = 4'h5;
    localparam logic [3:0] OP_BRANCH = 4'h6;
    localparam logic [3:0] OP_ALUI   = 4'h8;
    localparam logic [3:0] OP_LW     = 4'h9;
    localparam logic [3:0] OP_CMPI   = 4'hA;
    localparam logic [3:0] OP_JAL    = 4'hB;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JAL = 2'd2;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_ALUR, OP_CMPR, OP_SW, OP_BRANCH,
            OP_ALUI, OP_LW, OP_CMPI, OP_JAL: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory ready; flags when the tolerated wait is used up.
// Latency: expired is a combinational compare of the registered count.
// Backpressure: none; clr has priority over cnt_en.
// Ports: clk, reset_n (async active-low), clr (restart at 0), cnt_en (count this cycle),
//        expired (count has reached MEM_TIMEOUT).
module mem_wait_timer #(
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/[MEM]/WB with datapath strobes and next-PC select.
// Latency: ALU/CMP/JAL 4, BRANCH 3, LW 5, SW 4 cycles with memories ready at once.
// Backpressure: stalls in FETCH/MEM until imem_ready/dmem_ready; halts after MEM_TIMEOUT wait cycles.
// Ports: clk, reset_n (async active-low); run, op, br_taken, imem_ready, dmem_ready in;
//        fetch_req, ir_we, dec_we, alu_we, dmem_re, dmem_we, rf_we, pc_we, pc_sel,
//        state, retired, illegal, bus_err out.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [3:0]       op,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             fetch_req,
    output logic             ir_we,
    output logic             dec_we,
    output logic             alu_we,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             bus_err
);

    state_t     st_q;
    logic [3:0] op_q;

    logic retire;
    logic enter_fetch;
    logic enter_mem;
    logic timer_clr;
    logic timer_en;
    logic expired;

    // Retire points: taken/untaken branch in EXEC, store on its ready cycle, any WB.
    always_comb begin
        retire      = 1'b0;
        enter_fetch = 1'b0;
        enter_mem   = 1'b0;
        timer_en    = 1'b0;
        retire      = (st_q == ST_EXEC && op_q == OP_BRANCH) ||
                      (st_q == ST_MEM  && op_q == OP_SW && dmem_ready) ||
                      (st_q == ST_WB);
        enter_fetch = run && (st_q == ST_IDLE || retire);
        enter_mem   = (st_q == ST_EXEC) && (op_q == OP_LW || op_q == OP_SW);
        timer_en    = (st_q == ST_FETCH && !imem_ready) ||
                      (st_q == ST_MEM   && !dmem_ready);
    end

    // One timer serves both waits: it restarts whenever a wait state is entered.
    assign timer_clr = enter_fetch || enter_mem;

    mem_wait_timer #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (timer_clr),
        .cnt_en  (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= ST_IDLE;
            op_q    <= '0;
            retired <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (run) st_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    // A ready arriving on the expiry cycle still completes the fetch.
                    if (imem_ready) begin
                        st_q <= ST_DECODE;
                    end else if (expired) begin
                        st_q    <= ST_HALT;
                        bus_err <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    op_q <= op;
                    if (!op_legal(op)) begin
                        st_q    <= ST_HALT;
                        illegal <= 1'b1;
                    end else begin
                        st_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_LW || op_q == OP_SW) begin
                        st_q <= ST_MEM;
                    end else if (op_q != OP_BRANCH) begin
                        st_q <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (op_q == OP_LW) st_q <= ST_WB;
                    end else if (expired) begin
                        st_q    <= ST_HALT;
                        bus_err <= 1'b1;
                    end
                end
                ST_WB:   ;
                ST_HALT: ;
                default: st_q <= ST_HALT;
            endcase

            // Retirement overrides the per-state next state above; run only
            // decides whether another instruction starts.
            if (retire) begin
                retired <= retired + 1'b1;
                st_q    <= run ? ST_FETCH : ST_IDLE;
            end
        end
    end

    always_comb begin
        fetch_req = 1'b0;
        ir_we     = 1'b0;
        dec_we    = 1'b0;
        alu_we    = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEQ;
        case (st_q)
            ST_FETCH: begin
                fetch_req = 1'b1;
                ir_we     = imem_ready;
            end
            ST_DECODE: dec_we = 1'b1;
            ST_EXEC: begin
                alu_we = 1'b1;
                if (op_q == OP_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? PC_BR : PC_SEQ;
                end
            end
            ST_MEM: begin
                dmem_re = (op_q == OP_LW);
                dmem_we = (op_q == OP_SW);
                pc_we   = (op_q == OP_SW) && dmem_ready;
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                pc_sel = (op_q == OP_JAL) ? PC_JAL : PC_SEQ;
            end
            default: ;
        endcase
    end

    assign state = st_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    localparam int CW   = 4;
    localparam int TMO  = 255;
    localparam int WRAP = 1 << CW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          run;
    logic [3:0]    op;
    logic          br_taken;
    logic          imem_ready;
    logic          dmem_ready;
    logic          fetch_req, ir_we, dec_we, alu_we, dmem_re, dmem_we, rf_we, pc_we;
    logic [1:0]    pc_sel;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic          illegal, bus_err;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(CW), .TMO_W(8), .MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .op         (op),
        .br_taken   (br_taken),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .fetch_req  (fetch_req),
        .ir_we      (ir_we),
        .dec_we     (dec_we),
        .alu_we     (alu_we),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .state      (state),
        .retired    (retired),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    // One clock cycle: the inputs applied and the outputs the spec demands.
    typedef struct {
        logic          rst_n, run, br, imem, dmem;
        logic [3:0]    op;
        logic [2:0]    st;
        logic          fetch_req, ir_we, dec_we, alu_we, dmem_re, dmem_we, rf_we, pc_we;
        logic [1:0]    pc_sel;
        logic [CW-1:0] ret;
        logic          ill, berr;
    } cyc_t;

    // Phase numbers as the spec encodes the visible state output.
    localparam logic [2:0] P_IDLE = 3'd0, P_FETCH = 3'd1, P_DEC = 3'd2, P_EXEC = 3'd3,
                           P_MEM = 3'd4, P_WB = 3'd5, P_HALT = 3'd6;

    // Instruction outcome after generation.
    localparam int S_CONT = 0, S_IDLE = 1, S_HALT = 2, S_RST = 3;

    cyc_t q[$];
    cyc_t c;
    int   ret_m  = 0;
    bit   ill_m  = 0;
    bit   berr_m = 0;
    int   errors = 0;
    int   checks = 0;
    int   cyc_no = 0;

    function automatic bit is_legal(input logic [3:0] o);
        return o inside {4'h0, 4'h2, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    task automatic nc(input logic [2:0] s);
        c.rst_n = 1'b1;
        c.run   = 1'($urandom_range(0, 1));
        c.op    = 4'($urandom_range(0, 15));
        c.br    = 1'($urandom_range(0, 1));
        c.imem  = 1'($urandom_range(0, 1));
        c.dmem  = 1'($urandom_range(0, 1));
        c.st    = s;
        {c.fetch_req, c.ir_we, c.dec_we, c.alu_we, c.dmem_re, c.dmem_we, c.rf_we, c.pc_we} = '0;
        c.pc_sel = 2'd0;
        c.ret    = CW'(ret_m);
        c.ill    = ill_m;
        c.berr   = berr_m;
    endtask

    task automatic bump();
        ret_m = (ret_m + 1) % WRAP;
    endtask

    task automatic gen_reset(input int n);
        ret_m = 0; ill_m = 0; berr_m = 0;
        for (int i = 0; i < n; i++) begin
            nc(P_IDLE);
            c.rst_n = 1'b0;
            q.push_back(c);
        end
    endtask

    task automatic gen_idle(input int n);
        for (int i = 0; i < n; i++) begin
            nc(P_IDLE); c.run = 1'b0; q.push_back(c);
        end
        nc(P_IDLE); c.run = 1'b1; q.push_back(c);
    endtask

    task automatic gen_halt(input int n);
        for (int i = 0; i < n; i++) begin
            nc(P_HALT); q.push_back(c);
        end
    endtask

    // Expected trace of one instruction: fw/mw are ready wait cycles, rn is run at
    // the retire point, abort_at resets the DUT at that MEM cycle (-1: never).
    task automatic gen_instr(input logic [3:0] o, input int fw, input int mw, input logic bt,
                             input logic rn, input int abort_at, output int status);
        status = S_CONT;
        for (int i = 0; ; i++) begin
            nc(P_FETCH);
            c.fetch_req = 1'b1;
            c.imem  = (i == fw);
            c.ir_we = (i == fw);
            q.push_back(c);
            if (i == fw) break;
            if (i == TMO) begin berr_m = 1; status = S_HALT; return; end
        end
        nc(P_DEC); c.dec_we = 1'b1; c.op = o; q.push_back(c);
        if (!is_legal(o)) begin ill_m = 1; status = S_HALT; return; end
        nc(P_EXEC); c.alu_we = 1'b1;
        if (o == 4'h6) begin
            c.br = bt; c.pc_we = 1'b1; c.pc_sel = bt ? 2'd1 : 2'd0; c.run = rn;
            q.push_back(c); bump();
            status = rn ? S_CONT : S_IDLE;
            return;
        end
        q.push_back(c);
        if (o == 4'h5 || o == 4'h9) begin
            for (int i = 0; ; i++) begin
                if (i == abort_at) begin gen_reset(2); status = S_RST; return; end
                nc(P_MEM);
                c.dmem    = (i == mw);
                c.dmem_re = (o == 4'h9);
                c.dmem_we = (o == 4'h5);
                if (o == 4'h5 && i == mw) begin c.pc_we = 1'b1; c.run = rn; end
                q.push_back(c);
                if (i == mw) begin
                    if (o == 4'h5) begin bump(); status = rn ? S_CONT : S_IDLE; return; end
                    break;
                end
                if (i == TMO) begin berr_m = 1; status = S_HALT; return; end
            end
        end
        nc(P_WB); c.rf_we = 1'b1; c.pc_we = 1'b1; c.pc_sel = (o == 4'hB) ? 2'd2 : 2'd0; c.run = rn;
        q.push_back(c); bump();
        status = rn ? S_CONT : S_IDLE;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // The single per-cycle compare: drive the cycle's inputs, check every output.
    task automatic run_queue();
        cyc_t e;
        logic [18:0] act, expv;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            reset_n = e.rst_n; run = e.run; op = e.op; br_taken = e.br;
            imem_ready = e.imem; dmem_ready = e.dmem;
            #1;
            act  = {state, fetch_req, ir_we, dec_we, alu_we, dmem_re, dmem_we, rf_we, pc_we,
                    pc_sel, retired, illegal, bus_err};
            expv = {e.st, e.fetch_req, e.ir_we, e.dec_we, e.alu_we, e.dmem_re, e.dmem_we,
                    e.rf_we, e.pc_we, e.pc_sel, e.ret, e.ill, e.berr};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle %0d: got st=%0d fr/ir/dec/alu/re/we/rf/pc=%b sel=%0d ret=%0d ill=%b berr=%b, expected st=%0d strobes=%b sel=%0d ret=%0d ill=%b berr=%b",
                         cyc_no, act[18:16], act[15:8], act[7:6], act[5:2], act[1], act[0],
                         expv[18:16], expv[15:8], expv[7:6], expv[5:2], expv[1], expv[0]);
            end
            cyc_no++;
        end
    endtask

    // Check registered outputs one edge after the queued trace ends.
    task automatic post(input string tag, input int st_e, input int ret_e, input int ill_e, input int be_e);
        @(posedge clk); #1;
        chk({tag, "_state"},   int'(state),   st_e);
        chk({tag, "_retired"}, int'(retired), ret_e);
        chk({tag, "_illegal"}, int'(illegal), ill_e);
        chk({tag, "_bus_err"}, int'(bus_err), be_e);
    endtask

    function automatic logic [3:0] pick_op();
        logic [3:0] legal_ops [8]   = '{4'h0, 4'h2, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
        logic [3:0] illegal_ops [8] = '{4'h1, 4'h3, 4'h4, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
        if ($urandom_range(0, 11) == 0) return illegal_ops[$urandom_range(0, 7)];
        return legal_ops[$urandom_range(0, 7)];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int s, n0;
        reset_n = 1'b0; run = 1'b0; op = '0; br_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;

        gen_reset(3);
        run_queue();
        chk("reset_state", int'(state), 0);
        chk("reset_retired", int'(retired), 0);

        // ALUR back to back: 4 cycles, then next FETCH.
        gen_idle(1);
        n0 = q.size(); gen_instr(4'h0, 0, 0, 1'b0, 1'b1, -1, s);
        chk("alur_len", q.size() - n0, 4);
        run_queue(); post("alur", 1, 1, 0, 0);

        // LW with data ready on the 4th MEM cycle.
        n0 = q.size(); gen_instr(4'h9, 0, 3, 1'b0, 1'b1, -1, s);
        chk("lw_len", q.size() - n0, 8);
        run_queue();

        n0 = q.size(); gen_instr(4'h6, 0, 0, 1'b1, 1'b1, -1, s);
        chk("br_taken_len", q.size() - n0, 3);
        gen_instr(4'h6, 1, 0, 1'b0, 1'b1, -1, s);
        n0 = q.size(); gen_instr(4'h5, 0, 0, 1'b0, 1'b1, -1, s);
        chk("sw_len", q.size() - n0, 4);
        gen_instr(4'h5, 0, 2, 1'b0, 1'b1, -1, s);
        n0 = q.size(); gen_instr(4'hB, 0, 0, 1'b0, 1'b1, -1, s);
        chk("jal_len", q.size() - n0, 4);
        gen_instr(4'h8, 2, 0, 1'b0, 1'b0, -1, s);
        chk("model_ret_after_directed", ret_m, 8);
        run_queue(); post("run_drop", 0, 8, 0, 0);

        // Illegal opcode halts after DECODE and stays halted.
        gen_idle(2);
        n0 = q.size(); gen_instr(4'h3, 0, 0, 1'b0, 1'b1, -1, s);
        chk("illegal_len", q.size() - n0, 2);
        gen_halt(20);
        run_queue(); post("illegal", 6, 8, 1, 0);
        gen_reset(2);
        run_queue(); post("illegal_rst", 0, 0, 0, 0);

        // Data memory never answers: 256 MEM cycles then HALT.
        gen_idle(0);
        n0 = q.size(); gen_instr(4'h9, 0, 100000, 1'b0, 1'b1, -1, s);
        chk("lw_tmo_len", q.size() - n0, 3 + TMO + 1);
        gen_halt(3);
        run_queue(); post("lw_tmo", 6, 0, 0, 1);

        // Instruction memory never answers.
        gen_reset(1); gen_idle(0);
        n0 = q.size(); gen_instr(4'h0, 100000, 0, 1'b0, 1'b1, -1, s);
        chk("fetch_tmo_len", q.size() - n0, TMO + 1);
        run_queue(); post("fetch_tmo", 6, 0, 0, 1);

        // Ready on the expiry cycle wins, for both waits.
        gen_reset(1); gen_idle(0);
        gen_instr(4'h0, TMO, 0, 1'b0, 1'b1, -1, s);
        n0 = q.size(); gen_instr(4'h9, 0, TMO, 1'b0, 1'b1, -1, s);
        chk("lw_edge_len", q.size() - n0, 3 + TMO + 1 + 1);
        run_queue(); post("edge", 1, 2, 0, 0);

        // Reset during MEM abandons the load.
        gen_reset(1); gen_idle(0);
        gen_instr(4'h9, 0, 100000, 1'b0, 1'b1, 2, s);
        run_queue(); post("mem_abort", 0, 0, 0, 0);

        // Randomized instruction stream; retired wraps at 2**CW.
        gen_idle(1);
        for (int k = 0; k < 160; k++) begin
            gen_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), -1, s);
            if (s == S_IDLE || s == S_RST) begin
                gen_idle($urandom_range(0, 2));
            end else if (s == S_HALT) begin
                gen_halt($urandom_range(1, 4));
                gen_reset(1);
                gen_idle(0);
            end
            run_queue();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
